// File: rtl/seg_pattern_encoder.sv
// Active-low 7-segment pattern decoder feeding a 2-entry in-order result FIFO.
// Optional saturating illegal-pattern counter (ERR_CNT) enabled by `define SEG_ERR_CNT_EN.
module seg_pattern_encoder (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       IN_VLD,
    output logic       IN_RDY,
    input  logic [6:0] SEG,
    output logic       OUT_VLD,
    input  logic       OUT_RDY,
    output logic [3:0] OUT_CODE,
    output logic       OUT_BLANK,
    output logic       OUT_ERR
`ifdef SEG_ERR_CNT_EN
    ,
    output logic [7:0] ERR_CNT
`endif
);

    typedef enum logic [1:0] {StEmpty, StOne, StFull} occ_t;

    typedef struct packed {
        logic [3:0] code;
        logic       blank;
        logic       err;
    } entry_t;

    function automatic entry_t decode(input logic [6:0] seg);
        entry_t e;
        e = '{code: 4'h0, blank: 1'b0, err: 1'b0};
        case (seg)
            7'b0000001: e.code = 4'h0;
            7'b1001111: e.code = 4'h1;
            7'b0010010: e.code = 4'h2;
            7'b0000110: e.code = 4'h3;
            7'b1001100: e.code = 4'h4;
            7'b0100100: e.code = 4'h5;
            7'b0100000: e.code = 4'h6;
            7'b0001111: e.code = 4'h7;
            7'b0000000: e.code = 4'h8;
            7'b0000100: e.code = 4'h9;
            7'b0001000: e.code = 4'hA;
            7'b1100000: e.code = 4'hB;
            7'b0110001: e.code = 4'hC;
            7'b1000010: e.code = 4'hD;
            7'b0110000: e.code = 4'hE;
            7'b0111000: e.code = 4'hF;
            7'b1111111: e.blank = 1'b1;
            default:    e.err = 1'b1;
        endcase
        return e;
    endfunction

    occ_t   state;
    entry_t head;
    entry_t tail;
    entry_t new_entry;
    logic   push;
    logic   pop;

    assign new_entry = decode(SEG);
    assign IN_RDY    = !Reset && (state != StFull);
    assign OUT_VLD   = (state != StEmpty);
    assign push      = IN_VLD && IN_RDY;
    assign pop       = OUT_VLD && OUT_RDY;

    // Result fields read as zero whenever no entry is presented.
    assign OUT_CODE  = OUT_VLD ? head.code  : 4'h0;
    assign OUT_BLANK = OUT_VLD ? head.blank : 1'b0;
    assign OUT_ERR   = OUT_VLD ? head.err   : 1'b0;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= StEmpty;
            head  <= '0;
            tail  <= '0;
        end else begin
            unique case (state)
                StEmpty: begin
                    if (push) begin
                        head  <= new_entry;
                        state <= StOne;
                    end
                end
                StOne: begin
                    if (push && !pop) begin
                        tail  <= new_entry;
                        state <= StFull;
                    end else if (!push && pop) begin
                        state <= StEmpty;
                    end else if (push && pop) begin
                        // Old head leaves as the new entry arrives: it becomes the head.
                        head <= new_entry;
                    end
                end
                StFull: begin
                    if (pop) begin
                        head  <= tail;
                        state <= StOne;
                    end
                end
                default: state <= StEmpty;
            endcase
        end
    end

`ifdef SEG_ERR_CNT_EN
    logic [7:0] err_cnt;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            err_cnt <= 8'h00;
        end else if (push && new_entry.err && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'h01;
        end
    end

    assign ERR_CNT = err_cnt;
`endif

endmodule

// File: tb/tb_seg_pattern_encoder.sv
// Bench for seg_pattern_encoder: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_seg_pattern_encoder;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       IN_VLD = 1'b0;
    logic       IN_RDY;
    logic [6:0] SEG = 7'h7F;
    logic       OUT_VLD;
    logic       OUT_RDY = 1'b0;
    logic [3:0] OUT_CODE;
    logic       OUT_BLANK;
    logic       OUT_ERR;
`ifdef SEG_ERR_CNT_EN
    logic [7:0] ERR_CNT;
`endif

    int checks = 0;
    int errors = 0;

    seg_pattern_encoder dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .IN_VLD    (IN_VLD),
        .IN_RDY    (IN_RDY),
        .SEG       (SEG),
        .OUT_VLD   (OUT_VLD),
        .OUT_RDY   (OUT_RDY),
        .OUT_CODE  (OUT_CODE),
        .OUT_BLANK (OUT_BLANK),
        .OUT_ERR   (OUT_ERR)
`ifdef SEG_ERR_CNT_EN
        ,
        .ERR_CNT   (ERR_CNT)
`endif
    );

    always #5 Clock = ~Clock;

    // Index i of this table is the digit that pattern shows.
    logic [6:0] legal [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    // Model entry: {code[3:0], blank, err}
    logic [5:0] mq [$];
    int         mcnt = 0;

    function automatic logic [5:0] model_decode(input logic [6:0] s);
        for (int i = 0; i < 16; i++) begin
            if (s == legal[i]) return {4'(i), 2'b00};
        end
        if (s == 7'h7F) return 6'b000010;
        return 6'b000001;
    endfunction

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    always @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            mq.delete();
            mcnt = 0;
        end else begin
            automatic bit acc = IN_VLD && (mq.size() < 2);
            automatic bit pp  = (mq.size() > 0) && OUT_RDY;
            automatic logic [5:0] e = model_decode(SEG);
            if (pp) void'(mq.pop_front());
            if (acc) begin
                mq.push_back(e);
                if (e[0] && mcnt < 255) mcnt++;
            end
        end
    end

    always @(negedge Clock) begin
        automatic logic [5:0] h = (mq.size() > 0) ? mq[0] : 6'h00;
        chk("in_rdy",  8'(IN_RDY),  8'(!Reset && mq.size() < 2));
        chk("out_vld", 8'(OUT_VLD), 8'(mq.size() > 0));
        chk("payload", 8'({OUT_CODE, OUT_BLANK, OUT_ERR}), 8'(h));
`ifdef SEG_ERR_CNT_EN
        chk("err_cnt", ERR_CNT, 8'(mcnt));
`endif
    end

    task automatic tick();
        @(posedge Clock);
        #2;
    endtask

    initial begin
        #1;
        chk("rst_in_rdy", 8'(IN_RDY), 8'd0);
        chk("rst_out_vld", 8'(OUT_VLD), 8'd0);
        chk("rst_payload", 8'({OUT_CODE, OUT_BLANK, OUT_ERR}), 8'd0);
        repeat (2) tick();
        Reset = 1'b0;
        #1;
        chk("post_rst_in_rdy", 8'(IN_RDY), 8'd1);

        // Single digit through with downstream ready.
        tick();
        IN_VLD = 1'b1; SEG = 7'b0100100; OUT_RDY = 1'b1;
        tick();
        IN_VLD = 1'b0;
        chk("t1_vld", 8'(OUT_VLD), 8'd1);
        chk("t1_code", 8'(OUT_CODE), 8'h5);
        chk("t1_flags", 8'({OUT_BLANK, OUT_ERR}), 8'd0);
        tick();
        chk("t1_popped", 8'(OUT_VLD), 8'd0);

        // Fill to FULL, hold a third pattern, then drain in order.
        OUT_RDY = 1'b0; IN_VLD = 1'b1; SEG = 7'b0000001;
        tick();
        SEG = 7'b0111000;
        tick();
        chk("t2_full_rdy", 8'(IN_RDY), 8'd0);
        SEG = 7'b1001111;
        tick();
        chk("t2_held_rdy", 8'(IN_RDY), 8'd0);
        chk("t2_head0", 8'(OUT_CODE), 8'h0);
        OUT_RDY = 1'b1;
        tick();
        chk("t2_head1", 8'(OUT_CODE), 8'hF);
        tick();
        IN_VLD = 1'b0;
        chk("t2_head2", 8'(OUT_CODE), 8'h1);
        tick();
        chk("t2_drained", 8'(OUT_VLD), 8'd0);

        // Blank and illegal patterns.
        IN_VLD = 1'b1; SEG = 7'b1111111;
        tick();
        SEG = 7'b1111110;
        chk("t3_blank", 8'({OUT_CODE, OUT_BLANK, OUT_ERR}), 8'b000010);
        tick();
        IN_VLD = 1'b0;
        chk("t3_err", 8'({OUT_CODE, OUT_BLANK, OUT_ERR}), 8'b000001);
        tick();

        // Streaming in ONE: every cycle pushes and pops, digits 0..F in order.
        IN_VLD = 1'b1; SEG = legal[0];
        tick();
        for (int i = 1; i < 16; i++) begin
            chk("t4_code", 8'(OUT_CODE), 8'(i - 1));
            chk("t4_rdy", 8'({IN_RDY, OUT_VLD}), 8'b11);
            SEG = legal[i];
            tick();
        end
        IN_VLD = 1'b0;
        chk("t4_last", 8'(OUT_CODE), 8'hF);
        tick();

        // Asynchronous reset while FULL.
        OUT_RDY = 1'b0; IN_VLD = 1'b1; SEG = legal[3];
        tick();
        SEG = legal[7];
        tick();
        IN_VLD = 1'b0;
        chk("t5_full", 8'({IN_RDY, OUT_VLD}), 8'b01);
        #1 Reset = 1'b1;
        #1;
        chk("t5_async", 8'({IN_RDY, OUT_VLD}), 8'b00);
        tick();
        Reset = 1'b0;
        #1;
        chk("t5_after", 8'({IN_RDY, OUT_VLD}), 8'b10);

        // Randomized traffic with the occasional reset.
        for (int n = 0; n < 600; n++) begin
            tick();
            if ($urandom_range(0, 99) == 0) begin
                Reset = 1'b1;
                tick();
                Reset = 1'b0;
            end
            IN_VLD  = ($urandom_range(0, 2) != 0);
            OUT_RDY = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 3))
                0, 1:    SEG = legal[$urandom_range(0, 15)];
                2:       SEG = 7'h7F;
                default: SEG = 7'($urandom);
            endcase
        end
        IN_VLD = 1'b0; OUT_RDY = 1'b1;
        tick();
        tick();

`ifdef SEG_ERR_CNT_EN
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        OUT_RDY = 1'b1; IN_VLD = 1'b1; SEG = 7'b1111110;
        repeat (300) tick();
        chk("t6_sat", ERR_CNT, 8'd255);
        SEG = legal[2];
        tick();
        IN_VLD = 1'b0;
        tick();
        chk("t6_hold", ERR_CNT, 8'd255);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
